// File: rtl/cv32e41p_fetch_sequencer.sv
// Instruction fetch sequencer: issues word-aligned OBI requests under a credit rule,
// buffers responses in a small FIFO for the aligner and discards old-stream data on redirect.
module cv32e41p_fetch_sequencer #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en_i,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_addr_i,
   input  logic              hwlp_jump_i,
   input  logic [ADDR_W-1:0] hwlp_target_i,
   output logic              instr_req_o,
   output logic [ADDR_W-1:0] instr_addr_o,
   input  logic              instr_gnt_i,
   input  logic              instr_rvalid_i,
   input  logic [31:0]       instr_rdata_i,
   output logic              fetch_valid_o,
   output logic [31:0]       fetch_rdata_o,
   input  logic              aligner_ready_i,
   output logic              busy_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e            state_reg, state_next;
   logic [ADDR_W-1:0] next_addr_reg, next_addr_next;
   logic [ADDR_W-1:0] hold_addr_reg, hold_addr_next;
   logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
   logic [CNT_W-1:0]  discard_reg, discard_next;
   logic [CNT_W-1:0]  fifo_count_reg, fifo_count_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic              req_pending_reg, req_pending_next;
   logic [31:0]       fifo_mem [FIFO_DEPTH];

   logic              redirect;
   logic [ADDR_W-1:0] target;
   logic              grant;
   logic              credit_ok;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_push;
   logic              fifo_pop;

   assign redirect = branch_i | hwlp_jump_i;
   assign target   = (branch_i ? branch_addr_i : hwlp_target_i) & ~ADDR_W'(3);

   // Outstanding responses each reserve a FIFO slot, so a response can never overflow it.
   assign credit_ok  = ({1'b0, outstanding_reg} + {1'b0, fifo_count_reg}) < (CNT_W + 1)'(FIFO_DEPTH);
   assign fifo_empty = (fifo_count_reg == '0);
   assign fifo_full  = (fifo_count_reg == CNT_W'(FIFO_DEPTH));

   always_comb begin
      state_next  = state_reg;
      instr_req_o = 1'b0;
      case (state_reg)
         IDLE: begin
            if (fetch_en_i || redirect) begin
               state_next = RUN;
            end
         end
         RUN: begin
            instr_req_o = req_pending_reg | (fetch_en_i & credit_ok);
            if (redirect && instr_req_o && !instr_gnt_i) begin
               state_next = HOLD;
            end else if (!fetch_en_i && !(instr_req_o && !instr_gnt_i)) begin
               state_next = IDLE;
            end
         end
         HOLD: begin
            instr_req_o = 1'b1;
            if (instr_gnt_i) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign grant            = instr_req_o & instr_gnt_i;
   assign req_pending_next = instr_req_o & ~instr_gnt_i;
   assign instr_addr_o     = (state_reg == HOLD) ? hold_addr_reg : next_addr_reg;
   assign hold_addr_next   = (state_reg == HOLD) ? hold_addr_reg : next_addr_reg;
   assign busy_o           = (outstanding_reg != '0) | instr_req_o;

   always_comb begin
      next_addr_next = next_addr_reg;
      if (redirect) begin
         next_addr_next = target;
      end else if (grant && state_reg != HOLD) begin
         next_addr_next = next_addr_reg + ADDR_W'(4);
      end
   end

   assign outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(instr_rvalid_i);

   // After a redirect every in-flight response belongs to the old stream, including
   // the stalled request finally granted in HOLD.
   always_comb begin
      discard_next = discard_reg;
      if (instr_rvalid_i && discard_reg != '0) begin
         discard_next = discard_next - CNT_W'(1);
      end
      if (state_reg == HOLD && grant) begin
         discard_next = discard_next + CNT_W'(1);
      end
      if (redirect) begin
         discard_next = outstanding_next;
      end
   end

   assign fifo_push = instr_rvalid_i & ~redirect & (discard_reg == '0);
   assign fifo_pop  = ~fifo_empty & aligner_ready_i & ~redirect;

   always_comb begin
      fifo_count_next = fifo_count_reg;
      rd_ptr_next     = rd_ptr_reg;
      wr_ptr_next     = wr_ptr_reg;
      if (redirect) begin
         fifo_count_next = '0;
         rd_ptr_next     = '0;
         wr_ptr_next     = '0;
      end else begin
         fifo_count_next = fifo_count_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
         if (fifo_push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   assign fetch_valid_o = ~fifo_empty;
   assign fetch_rdata_o = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         next_addr_reg   <= '0;
         hold_addr_reg   <= '0;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         fifo_count_reg  <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         req_pending_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         next_addr_reg   <= next_addr_next;
         hold_addr_reg   <= hold_addr_next;
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
         fifo_count_reg  <= fifo_count_next;
         rd_ptr_reg      <= rd_ptr_next;
         wr_ptr_reg      <= wr_ptr_next;
         req_pending_reg <= req_pending_next;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr_reg] <= instr_rdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(fifo_push && fifo_full && !fifo_pop));
      end
   end

endmodule

// File: tb/tb_cv32e41p_fetch_sequencer.sv
// Directed bench for the fetch sequencer: a one-cycle-latency memory responder plus
// hand-computed address and word sequences for each scenario.
module tb_cv32e41p_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        fetch_en_i;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic        hwlp_jump_i;
   logic [31:0] hwlp_target_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        fetch_valid_o;
   logic [31:0] fetch_rdata_o;
   logic        aligner_ready_i;
   logic        busy_o;

   cv32e41p_fetch_sequencer #(
      .FIFO_DEPTH(2),
      .ADDR_W    (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en_i     (fetch_en_i),
      .branch_i       (branch_i),
      .branch_addr_i  (branch_addr_i),
      .hwlp_jump_i    (hwlp_jump_i),
      .hwlp_target_i  (hwlp_target_i),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .fetch_valid_o  (fetch_valid_o),
      .fetch_rdata_o  (fetch_rdata_o),
      .aligner_ready_i(aligner_ready_i),
      .busy_o         (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors;
   int          miscompares;
   logic        gnt_en;
   logic        rsp_en;
   logic [31:0] rsp_q[$];
   logic [31:0] issued[$];
   logic [31:0] delivered[$];
   int          n0;
   int          d0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] issued_at(input int i);
      return (i < issued.size()) ? issued[i] : 32'hBAD0_BAD0;
   endfunction

   function automatic logic [31:0] delivered_at(input int i);
      return (i < delivered.size()) ? delivered[i] : 32'hBAD1_BAD1;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Called at a negedge with inputs set; samples, books the cycle, drives the responder.
   task automatic tick();
      #1;
      if (instr_rvalid_i) void'(rsp_q.pop_front());
      if (instr_req_o && instr_gnt_i) begin
         issued.push_back(instr_addr_o);
         rsp_q.push_back(instr_addr_o);
      end
      if (fetch_valid_o && aligner_ready_i && !(branch_i || hwlp_jump_i))
         delivered.push_back(fetch_rdata_o);
      @(posedge clk);
      @(negedge clk);
      instr_gnt_i    = gnt_en;
      instr_rvalid_i = rsp_en && (rsp_q.size() > 0);
      instr_rdata_i  = instr_rvalid_i ? word_of(rsp_q[0]) : 32'h0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      fetch_en_i      = 1'b0;
      branch_i        = 1'b0;
      branch_addr_i   = 32'h0;
      hwlp_jump_i     = 1'b0;
      hwlp_target_i   = 32'h0;
      aligner_ready_i = 1'b0;
      gnt_en          = 1'b0;
      rsp_en          = 1'b0;
      rsp_q.delete();
      instr_gnt_i     = 1'b0;
      instr_rvalid_i  = 1'b0;
      instr_rdata_i   = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      rsp_q.delete();
      issued.delete();
      delivered.delete();
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_req"},   instr_req_o,   32'h0);
      check_val({pfx, "_addr"},  instr_addr_o,  32'h0);
      check_val({pfx, "_valid"}, fetch_valid_o, 32'h0);
      check_val({pfx, "_rdata"}, fetch_rdata_o, 32'h0);
      check_val({pfx, "_busy"},  busy_o,        32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      gnt_en      = 1'b0;
      rsp_en      = 1'b0;
      fetch_en_i  = 1'b0;
      branch_i    = 1'b0;
      hwlp_jump_i = 1'b0;
      branch_addr_i   = 32'h0;
      hwlp_target_i   = 32'h0;
      aligner_ready_i = 1'b0;
      instr_gnt_i     = 1'b0;
      instr_rvalid_i  = 1'b0;
      instr_rdata_i   = 32'h0;
      @(negedge clk);

      // Straight-line fetch with exact first-word latency
      do_reset();
      check_reset_outputs("rst");
      fetch_en_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; aligner_ready_i = 1'b1;
      check_val("t1_idle_req", instr_req_o, 32'h0);
      tick();
      check_val("t1_first_req", instr_req_o, 32'h1);
      check_val("t1_first_addr", instr_addr_o, 32'h0);
      tick();
      check_val("t1_rvalid_seen", instr_rvalid_i, 32'h1);
      check_val("t1_no_bypass", fetch_valid_o, 32'h0);
      check_val("t1_second_addr", instr_addr_o, 32'h4);
      tick();
      check_val("t1_valid_next", fetch_valid_o, 32'h1);
      check_val("t1_word0", fetch_rdata_o, word_of(32'h0));
      check_val("t1_credit_block", instr_req_o, 32'h0);
      run(8);
      check_val("t1_issue0", issued_at(0), 32'h0);
      check_val("t1_issue1", issued_at(1), 32'h4);
      check_val("t1_issue2", issued_at(2), 32'h8);
      check_val("t1_deliv0", delivered_at(0), word_of(32'h0));
      check_val("t1_deliv1", delivered_at(1), word_of(32'h4));
      check_val("t1_deliv2", delivered_at(2), word_of(32'h8));
      fetch_en_i = 1'b0;
      run(6);
      check_val("t1_stop_req", instr_req_o, 32'h0);
      check_val("t1_stop_busy", busy_o, 32'h0);
      check_val("t1_stop_valid", fetch_valid_o, 32'h0);

      // Back-pressure: two credits, then resume at the next address
      do_reset();
      fetch_en_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; aligner_ready_i = 1'b0;
      run(10);
      check_val("t2_issue_count", issued.size(), 32'd2);
      check_val("t2_req_low", instr_req_o, 32'h0);
      check_val("t2_head_valid", fetch_valid_o, 32'h1);
      check_val("t2_head_word", fetch_rdata_o, word_of(32'h0));
      aligner_ready_i = 1'b1;
      run(10);
      check_val("t2_resume_addr", issued_at(2), 32'h8);
      check_val("t2_deliv0", delivered_at(0), word_of(32'h0));
      check_val("t2_deliv1", delivered_at(1), word_of(32'h4));
      check_val("t2_deliv2", delivered_at(2), word_of(32'h8));

      // Branch with two outstanding, one response arriving in the redirect cycle
      do_reset();
      fetch_en_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b0; aligner_ready_i = 1'b1;
      run(3);
      check_val("t3_out2_req", instr_req_o, 32'h0);
      check_val("t3_out2_busy", busy_o, 32'h1);
      rsp_en = 1'b1;
      tick();
      check_val("t3_rvalid_at_br", instr_rvalid_i, 32'h1);
      branch_i = 1'b1; branch_addr_i = 32'h0000_0106;
      tick();
      branch_i = 1'b0;
      check_val("t3_new_addr", instr_addr_o, 32'h0000_0104);
      check_val("t3_drop_valid", fetch_valid_o, 32'h0);
      run(10);
      check_val("t3_issue2", issued_at(2), 32'h0000_0104);
      check_val("t3_deliv0", delivered_at(0), word_of(32'h0000_0104));
      check_val("t3_deliv1", delivered_at(1), word_of(32'h0000_0108));

      // Redirects during an ungranted request
      do_reset();
      fetch_en_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; aligner_ready_i = 1'b0;
      run(6);
      check_val("t4_fifo_full_valid", fetch_valid_o, 32'h1);
      branch_i = 1'b1; branch_addr_i = 32'h0000_0020; gnt_en = 1'b0; aligner_ready_i = 1'b1;
      tick();
      branch_i = 1'b0;
      check_val("t4_flushed", fetch_valid_o, 32'h0);
      check_val("t4_req", instr_req_o, 32'h1);
      check_val("t4_addr20", instr_addr_o, 32'h0000_0020);
      tick();
      branch_i = 1'b1; branch_addr_i = 32'h0000_0080;
      tick();
      branch_i = 1'b0;
      check_val("t4_hold_req", instr_req_o, 32'h1);
      check_val("t4_hold_addr", instr_addr_o, 32'h0000_0020);
      gnt_en = 1'b1;
      tick();
      check_val("t4_hold_addr2", instr_addr_o, 32'h0000_0020);
      tick();
      check_val("t4_after_gnt_addr", instr_addr_o, 32'h0000_0080);
      check_val("t4_after_gnt_req", instr_req_o, 32'h1);
      run(10);
      check_val("t4_issue2", issued_at(2), 32'h0000_0020);
      check_val("t4_issue3", issued_at(3), 32'h0000_0080);
      check_val("t4_deliv0", delivered_at(0), word_of(32'h0000_0080));

      // Branch and hardware-loop jump together: branch wins
      branch_i = 1'b1; branch_addr_i = 32'h0000_0200;
      hwlp_jump_i = 1'b1; hwlp_target_i = 32'h0000_0300;
      tick();
      branch_i = 1'b0; hwlp_jump_i = 1'b0;
      n0 = issued.size();
      d0 = delivered.size();
      run(10);
      check_val("t5_issue_new", issued_at(n0), 32'h0000_0200);
      check_val("t5_deliv_new", delivered_at(d0), word_of(32'h0000_0200));

      // Hardware-loop jump alone, low address bits ignored
      hwlp_jump_i = 1'b1; hwlp_target_i = 32'h0000_0302;
      tick();
      hwlp_jump_i = 1'b0;
      n0 = issued.size();
      d0 = delivered.size();
      run(10);
      check_val("t5_hwlp_issue", issued_at(n0), 32'h0000_0300);
      check_val("t5_hwlp_deliv", delivered_at(d0), word_of(32'h0000_0300));
      check_val("t5_hwlp_deliv1", delivered_at(d0 + 1), word_of(32'h0000_0304));

      // Address wrap, redirect from IDLE
      do_reset();
      fetch_en_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; aligner_ready_i = 1'b1;
      branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFF8;
      tick();
      branch_i = 1'b0;
      run(10);
      check_val("t6_issue0", issued_at(0), 32'hFFFF_FFF8);
      check_val("t6_issue1", issued_at(1), 32'hFFFF_FFFC);
      check_val("t6_issue2", issued_at(2), 32'h0000_0000);
      check_val("t6_deliv2", delivered_at(2), word_of(32'h0000_0000));

      // Reset in the middle of streaming
      do_reset();
      check_reset_outputs("midrst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
